// File: rtl/sr_pkg.sv
`default_nettype none
// =====================================================================
// sr_pkg : SR command encodings and command-generator FSM state type.
// Rev 1.0
// =====================================================================
package sr_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } sr_state_e;

endpackage
`default_nettype wire

// File: rtl/sr_debounce.sv
`default_nettype none
// =====================================================================
// sr_debounce : 2-flop synchronizer, stability debouncer, press detect.
// Rev 1.0
// =====================================================================
module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      // Any sample that agrees with the current level restarts the count.
      if (sync2_q != level_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rise_o = level_q & ~level_prev_q;

endmodule
`default_nettype wire

// File: rtl/sr_cmd_gen.sv
`default_nettype none
// =====================================================================
// sr_cmd_gen : push buttons -> single-cycle SR commands with hold-off.
// Optional macro SR_CMD_RESET_PRIORITY_EN. Rev 1.0
// =====================================================================
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       reset_btn,
  output logic [1:0] sr,
  output logic       busy,
  output logic       conflict
);

  localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;

  logic          set_rise;
  logic          reset_rise;
  logic          both_rise;
  logic [1:0]    new_cmd;
  logic [1:0]    req;

  sr_state_e     state_q, state_d;
  logic [1:0]    pend_q, pend_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [1:0]    sr_q, sr_d;
  logic          busy_q;
  logic          conflict_q;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (set_btn),
    .rise_o (set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (reset_btn),
    .rise_o (reset_rise)
  );

  assign both_rise = set_rise & reset_rise;

`ifdef SR_CMD_RESET_PRIORITY_EN
  assign new_cmd = both_rise  ? SR_RESET :
                   set_rise   ? SR_SET   :
                   reset_rise ? SR_RESET : SR_HOLD;
`else
  assign new_cmd = both_rise  ? SR_HOLD  :
                   set_rise   ? SR_SET   :
                   reset_rise ? SR_RESET : SR_HOLD;
`endif

  // A press landing on the hold-off exit cycle is newer than the pending one.
  assign req = (new_cmd != SR_HOLD) ? new_cmd : pend_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    hcnt_d  = hcnt_q;
    sr_d    = SR_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (new_cmd != SR_HOLD) begin
          state_d = ST_ISSUE;
          sr_d    = new_cmd;
        end
      end
      ST_ISSUE: begin
        state_d = ST_HOLDOFF;
        hcnt_d  = HW'(HOLDOFF_CYCLES - 1);
        if (new_cmd != SR_HOLD) pend_d = new_cmd;
      end
      ST_HOLDOFF: begin
        if (hcnt_q == '0) begin
          if (req != SR_HOLD) begin
            state_d = ST_ISSUE;
            sr_d    = req;
            pend_d  = SR_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q - 1'b1;
          if (new_cmd != SR_HOLD) pend_d = new_cmd;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= SR_HOLD;
      hcnt_q     <= '0;
      sr_q       <= SR_HOLD;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      hcnt_q     <= hcnt_d;
      sr_q       <= sr_d;
      busy_q     <= (state_d != ST_IDLE);
      conflict_q <= both_rise;
    end
  end

  assign sr       = sr_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule
`default_nettype wire
